// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel fractional clock-enable generator.
//
// Each channel emits single-cycle enable pulses at an average rate of f_clk*NUM/DEN. It uses a
// Bresenham accumulator, so non-integer ratios do not drift over time. NUM/DEN can be
// reprogrammed at runtime through a shadow register. A new setting is applied only at a pulse
// boundary, while the channel is stopped, or on sync, so a change never causes a glitch.
//
// Optional feature (define CLK_EN_GEN_PULSE_CNT_EN):
//   adds pulse_cnt, a 16-bit wrapping count of emitted pulses per channel.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   run          per-channel run; 0 freezes the accumulator and suppresses pulses
//   sync         restart every channel accumulator together
//   cfg_wr       one-cycle config write strobe
//   cfg_ch       target channel of cfg_wr (out-of-range values are ignored)
//   cfg_num      new NUM
//   cfg_den      new DEN
//   cfg_pending  per-channel: shadow config written but not yet applied
//   clk_en       per-channel registered enable pulse
//   pulse_cnt    (optional) per-channel 16-bit pulse count, channel i in bits [16*i +: 16]

module clk_en_gen #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ACC_WIDTH   = 24,
    parameter int unsigned DEFAULT_NUM = 1,
    parameter int unsigned DEFAULT_DEN = 4,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_CH-1:0]    run,
    input  logic                 sync,
    input  logic                 cfg_wr,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [ACC_WIDTH-1:0] cfg_num,
    input  logic [ACC_WIDTH-1:0] cfg_den,
    output logic [NUM_CH-1:0]    cfg_pending,
    output logic [NUM_CH-1:0]    clk_en
`ifdef CLK_EN_GEN_PULSE_CNT_EN
    ,
    output logic [NUM_CH*16-1:0] pulse_cnt
`endif
);

    localparam logic [ACC_WIDTH-1:0] DEF_NUM = ACC_WIDTH'(DEFAULT_NUM);
    localparam logic [ACC_WIDTH-1:0] DEF_DEN = ACC_WIDTH'(DEFAULT_DEN);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] CH_ID = CH_W'(i);

        logic [ACC_WIDTH-1:0] acc_q, acc_d;
        logic [ACC_WIDTH-1:0] num_q, den_q;
        logic [ACC_WIDTH-1:0] sh_num_q, sh_den_q;
        logic                 pend_q;
        logic                 en_q, en_d;

        logic                 hit;
        logic                 idle;
        logic                 ovf;
        logic                 apply;
        logic [ACC_WIDTH-1:0] num_eff;
        logic [ACC_WIDTH:0]   sum;

        always_comb begin
            hit     = cfg_wr && (cfg_ch == CH_ID);
            idle    = (num_q == '0) || (den_q == '0);
            // NUM >= DEN saturates to NUM = DEN: a pulse every running cycle with acc held at 0.
            num_eff = (num_q >= den_q) ? den_q : num_q;
            sum     = {1'b0, acc_q} + {1'b0, num_eff};
            ovf     = run[i] && !sync && !idle && (sum >= {1'b0, den_q});
            apply   = pend_q && (sync || !run[i] || ovf);

            acc_d = acc_q;
            en_d  = 1'b0;
            if (sync) begin
                acc_d = '0;
            end else if (run[i] && !idle) begin
                if (ovf) begin
                    en_d  = 1'b1;
                    // The result is < DEN, so modular ACC_WIDTH arithmetic is exact here.
                    acc_d = acc_q + num_eff - den_q;
                end else begin
                    acc_d = sum[ACC_WIDTH-1:0];
                end
            end
            // A new ratio always starts from a clean phase.
            if (apply) begin
                acc_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                acc_q    <= '0;
                num_q    <= DEF_NUM;
                den_q    <= DEF_DEN;
                sh_num_q <= '0;
                sh_den_q <= '0;
                pend_q   <= 1'b0;
                en_q     <= 1'b0;
            end else begin
                acc_q <= acc_d;
                en_q  <= en_d;
                if (apply) begin
                    num_q <= sh_num_q;
                    den_q <= sh_den_q;
                end
                // A write on the apply edge keeps the new value pending; the old shadow is applied.
                if (hit) begin
                    sh_num_q <= cfg_num;
                    sh_den_q <= cfg_den;
                end
                pend_q <= hit || (pend_q && !apply);
            end
        end

        assign clk_en[i]      = en_q;
        assign cfg_pending[i] = pend_q;

`ifdef CLK_EN_GEN_PULSE_CNT_EN
        logic [15:0] cnt_q;

        always_ff @(posedge clk) begin
            if (!reset_n || sync) begin
                cnt_q <= '0;
            end else if (en_d) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end

        assign pulse_cnt[16*i +: 16] = cnt_q;
`endif
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen. It runs three channels so that an out-of-range cfg_ch
// can be written. The reference model counts running steps k since the phase was cleared.
// The channel pulses when floor(k*N/D) increments, with N limited to D.
module tb_clk_en_gen;
    localparam int unsigned NCH  = 3;
    localparam int unsigned AW   = 24;
    localparam int unsigned CHW  = 2;
    localparam int unsigned DNUM = 1;
    localparam int unsigned DDEN = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NCH-1:0]   run;
    logic             sync;
    logic             cfg_wr;
    logic [CHW-1:0]   cfg_ch;
    logic [AW-1:0]    cfg_num;
    logic [AW-1:0]    cfg_den;
    logic [NCH-1:0]   cfg_pending;
    logic [NCH-1:0]   clk_en;
`ifdef CLK_EN_GEN_PULSE_CNT_EN
    logic [NCH*16-1:0] pulse_cnt;
`endif

    clk_en_gen #(
        .NUM_CH      (NCH),
        .ACC_WIDTH   (AW),
        .DEFAULT_NUM (DNUM),
        .DEFAULT_DEN (DDEN)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .sync        (sync),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_num     (cfg_num),
        .cfg_den     (cfg_den),
        .cfg_pending (cfg_pending),
        .clk_en      (clk_en)
`ifdef CLK_EN_GEN_PULSE_CNT_EN
        ,
        .pulse_cnt   (pulse_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    longint unsigned m_k   [NCH];
    longint unsigned m_num [NCH];
    longint unsigned m_den [NCH];
    longint unsigned m_sn  [NCH];
    longint unsigned m_sd  [NCH];
    logic [NCH-1:0]  m_en;
    logic [NCH-1:0]  m_pend;
    logic [15:0]     m_cnt [NCH];

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit              apply;
            longint unsigned n;
            apply = 1'b0;
            if (!reset_n) begin
                m_k[c] = 0; m_num[c] = DNUM; m_den[c] = DDEN; m_sn[c] = 0; m_sd[c] = 0;
                m_pend[c] = 1'b0; m_en[c] = 1'b0; m_cnt[c] = 16'd0;
                continue;
            end
            if (sync) begin
                m_k[c] = 0; m_en[c] = 1'b0; m_cnt[c] = 16'd0; apply = m_pend[c];
            end else if (!run[c]) begin
                m_en[c] = 1'b0; apply = m_pend[c];
            end else if (m_num[c] == 0 || m_den[c] == 0) begin
                m_en[c] = 1'b0;
            end else begin
                n = (m_num[c] < m_den[c]) ? m_num[c] : m_den[c];
                m_k[c]++;
                m_en[c] = ((m_k[c] * n) / m_den[c]) != (((m_k[c] - 1) * n) / m_den[c]);
                apply = m_pend[c] && m_en[c];
            end
            if (m_en[c]) m_cnt[c] = m_cnt[c] + 16'd1;
            if (apply) begin
                m_num[c] = m_sn[c]; m_den[c] = m_sd[c]; m_pend[c] = 1'b0; m_k[c] = 0;
            end
            if (cfg_wr && cfg_ch == c) begin
                m_sn[c] = cfg_num; m_sd[c] = cfg_den; m_pend[c] = 1'b1;
            end
        end
    endtask

    // Advance the model with the current inputs, then take one clock edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int unsigned n, input int unsigned d);
        cfg_wr = 1'b1; cfg_ch = CHW'(ch); cfg_num = AW'(n); cfg_den = AW'(d);
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run = '0; sync = 1'b0;
        step();
        step();
        n_checks++;
        if (clk_en !== 3'b000) $display("FAIL reset_clk_en got %b want 000", clk_en);
        else n_pass++;
        n_checks++;
        if (cfg_pending !== 3'b000) $display("FAIL reset_pending got %b want 000", cfg_pending);
        else n_pass++;
    endtask

    task automatic test_default_divide();
        reset_n = 1'b1; run = 3'b001;
        for (int e = 1; e <= 16; e++) begin
            step();
            n_checks++;
            if (clk_en[0] !== (e % 4 == 0))
                $display("FAIL default_div edge %0d got %b want %b", e, clk_en[0], e % 4 == 0);
            else n_pass++;
            n_checks++;
            if (clk_en !== m_en) $display("FAIL default_model got %b want %b", clk_en, m_en);
            else n_pass++;
        end
        n_checks++;
        if (cfg_pending !== 3'b000) $display("FAIL default_pending got %b want 000", cfg_pending);
        else n_pass++;
    endtask

    task automatic test_fractional();
        int cnt, last, bad_gap, bad_rep;
        bit p [1000];
        cfg_write(1, 3, 10);
        n_checks++;
        if (cfg_pending[1] !== 1'b1) $display("FAIL frac_pend_set got %b want 1", cfg_pending[1]);
        else n_pass++;
        step();
        n_checks++;
        if (cfg_pending[1] !== 1'b0) $display("FAIL frac_pend_clr got %b want 0", cfg_pending[1]);
        else n_pass++;
        run = 3'b011;
        cnt = 0; last = -1; bad_gap = 0; bad_rep = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            p[i] = clk_en[1];
            n_checks++;
            if (clk_en !== m_en) $display("FAIL frac_model cyc %0d got %b want %b", i, clk_en, m_en);
            else n_pass++;
            if (clk_en[1] === 1'b1) begin
                cnt++;
                if (last >= 0 && (i - last) != 3 && (i - last) != 4) bad_gap++;
                last = i;
            end
        end
        for (int i = 0; i < 990; i++) if (p[i] != p[i + 10]) bad_rep++;
        n_checks++;
        if (cnt != 300) $display("FAIL frac_count got %0d want 300", cnt);
        else n_pass++;
        n_checks++;
        if (bad_gap != 0) $display("FAIL frac_spacing bad gaps %0d want 0", bad_gap);
        else n_pass++;
        n_checks++;
        if (bad_rep != 0) $display("FAIL frac_period10 mismatches %0d want 0", bad_rep);
        else n_pass++;
    endtask

    task automatic test_switch();
        bit found;
        run = 3'b001; sync = 1'b1;
        step();
        sync = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (clk_en[0] === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL switch_first_pulse got none want pulse within 8 cycles");
        else n_pass++;
        step();
        step();
        cfg_write(0, 1, 2);
        n_checks++;
        if (cfg_pending[0] !== 1'b1 || clk_en[0] !== 1'b0)
            $display("FAIL switch_pending got pend=%b en=%b want 1 0", cfg_pending[0], clk_en[0]);
        else n_pass++;
        step();
        n_checks++;
        if (clk_en[0] !== 1'b1 || cfg_pending[0] !== 1'b0)
            $display("FAIL switch_apply got en=%b pend=%b want 1 0", clk_en[0], cfg_pending[0]);
        else n_pass++;
        for (int e = 1; e <= 6; e++) begin
            step();
            n_checks++;
            if (clk_en[0] !== (e % 2 == 0))
                $display("FAIL switch_div2 edge %0d got %b want %b", e, clk_en[0], e % 2 == 0);
            else n_pass++;
            n_checks++;
            if (clk_en !== m_en) $display("FAIL switch_model got %b want %b", clk_en, m_en);
            else n_pass++;
        end
    endtask

    task automatic test_sync();
        run = 3'b010;
        cfg_write(0, 1, 4);
        step();
        run = 3'b011; sync = 1'b1;
        step();
        sync = 1'b0;
        for (int e = 1; e <= 3; e++) step();
        n_checks++;
        if (clk_en !== 3'b000) $display("FAIL sync_pre got %b want 000", clk_en);
        else n_pass++;
        sync = 1'b1;
        step();
        sync = 1'b0;
        n_checks++;
        if (clk_en !== 3'b000) $display("FAIL sync_beats_ovf got %b want 000", clk_en);
        else n_pass++;
        for (int e = 1; e <= 4; e++) begin
            step();
            n_checks++;
            if (clk_en !== ((e == 4) ? 3'b011 : 3'b000))
                $display("FAIL sync_realign edge %0d got %b want %b", e, clk_en,
                         (e == 4) ? 3'b011 : 3'b000);
            else n_pass++;
            n_checks++;
            if (clk_en !== m_en) $display("FAIL sync_model got %b want %b", clk_en, m_en);
            else n_pass++;
        end
    endtask

    task automatic test_corner();
        int bad;
        run = 3'b000;
        cfg_write(0, 5, 5);
        step();
        run = 3'b001;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (clk_en[0] !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL corner_num_eq_den low cycles %0d want 0", bad);
        else n_pass++;
        cfg_write(0, 0, 5);
        step();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (clk_en[0] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL corner_num0 high cycles %0d want 0", bad);
        else n_pass++;
        cfg_write(0, 3, 0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (clk_en[0] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || cfg_pending[0] !== 1'b0)
            $display("FAIL corner_den0 bad cycles %0d pend %b want 0 0", bad, cfg_pending[0]);
        else n_pass++;
        cfg_write(3, 1, 1);
        n_checks++;
        if (cfg_pending !== 3'b000) $display("FAIL corner_bad_ch got %b want 000", cfg_pending);
        else n_pass++;
        n_checks++;
        if (clk_en !== m_en || cfg_pending !== m_pend)
            $display("FAIL corner_model got %b/%b want %b/%b", clk_en, cfg_pending, m_en, m_pend);
        else n_pass++;
    endtask

    task automatic test_random();
`ifdef CLK_EN_GEN_PULSE_CNT_EN
        logic [NCH*16-1:0] exp_cnt;
`endif
        for (int i = 0; i < 2000; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            run     = NCH'($urandom);
            sync    = ($urandom_range(0, 31) == 0);
            cfg_wr  = ($urandom_range(0, 3) == 0);
            cfg_ch  = CHW'($urandom_range(0, 3));
            cfg_num = AW'($urandom_range(0, 7));
            cfg_den = AW'($urandom_range(0, 7));
            step();
            n_checks++;
            if (clk_en !== m_en) $display("FAIL rand_clk_en cyc %0d got %b want %b", i, clk_en, m_en);
            else n_pass++;
            n_checks++;
            if (cfg_pending !== m_pend)
                $display("FAIL rand_pending cyc %0d got %b want %b", i, cfg_pending, m_pend);
            else n_pass++;
`ifdef CLK_EN_GEN_PULSE_CNT_EN
            for (int c = 0; c < NCH; c++) exp_cnt[16*c +: 16] = m_cnt[c];
            n_checks++;
            if (pulse_cnt !== exp_cnt)
                $display("FAIL rand_pulse_cnt cyc %0d got %h want %h", i, pulse_cnt, exp_cnt);
            else n_pass++;
`endif
        end
        reset_n = 1'b1; sync = 1'b0; cfg_wr = 1'b0;
    endtask

    task automatic test_reset_mid();
        run = 3'b001;
        cfg_write(0, 1, 2);
        n_checks++;
        if (cfg_pending[0] !== 1'b1) $display("FAIL rstmid_pend got %b want 1", cfg_pending[0]);
        else n_pass++;
        reset_n = 1'b0;
        step();
        n_checks++;
        if (clk_en !== 3'b000 || cfg_pending !== 3'b000)
            $display("FAIL rstmid_state got en=%b pend=%b want 000 000", clk_en, cfg_pending);
        else n_pass++;
`ifdef CLK_EN_GEN_PULSE_CNT_EN
        n_checks++;
        if (pulse_cnt !== '0) $display("FAIL rstmid_cnt got %h want 0", pulse_cnt);
        else n_pass++;
`endif
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_checks++;
            if (clk_en[0] !== (e % 4 == 0) || cfg_pending !== 3'b000)
                $display("FAIL rstmid_default edge %0d got en=%b pend=%b want %b 000", e, clk_en[0],
                         cfg_pending, e % 4 == 0);
            else n_pass++;
        end
    endtask

`ifdef CLK_EN_GEN_PULSE_CNT_EN
    task automatic test_cnt_wrap();
        run = 3'b000;
        cfg_write(0, 7, 7);
        sync = 1'b1;
        step();
        sync = 1'b0;
        run = 3'b001;
        for (int i = 0; i < 65535; i++) step();
        n_checks++;
        if (pulse_cnt[15:0] !== 16'hFFFF) $display("FAIL cnt_full got %h want ffff", pulse_cnt[15:0]);
        else n_pass++;
        step();
        n_checks++;
        if (pulse_cnt[15:0] !== 16'h0000) $display("FAIL cnt_wrap got %h want 0000", pulse_cnt[15:0]);
        else n_pass++;
    endtask
`endif

    initial begin
        reset_n = 1'b0; run = '0; sync = 1'b0;
        cfg_wr = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0;
        test_reset();
        test_default_divide();
        test_fractional();
        test_switch();
        test_sync();
        test_corner();
        test_random();
        test_reset_mid();
`ifdef CLK_EN_GEN_PULSE_CNT_EN
        test_cnt_wrap();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
